// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One input bit is consumed per cycle. Results at or above 10^DIGITS saturate to
// all nines and raise o_ovf. o_blank marks leading zero digits for the display mux.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf,
    output logic [DIGITS-1:0]     o_blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   sr;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic               ovf_acc;
    logic [CNT_W-1:0]   cnt;

    // Per-digit add-3 correction; digits are independent, so no carry crosses a digit boundary.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ? scratch[4*g +: 4] + 4'd3
                                                           : scratch[4*g +: 4];
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            sr      <= '0;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_bcd   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    // busy drops on the same edge as valid unless a new request arrives
                    o_busy  <= i_start;
                    if (i_start) begin
                        sr      <= i_bin;
                        scratch <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Shift the corrected scratch left, pulling in the next binary MSB.
                    scratch <= {adj[BCD_W-2:0], sr[BIN_W-1]};
                    sr      <= sr << 1;
                    // Anything leaving the top digit means the value is >= 10^DIGITS.
                    ovf_acc <= ovf_acc | adj[BCD_W-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_valid <= 1'b1;
                    state   <= IDLE;
                    if (ovf_acc) begin
                        o_bcd <= {DIGITS{4'h9}};
                        o_ovf <= 1'b1;
                    end else begin
                        o_bcd <= scratch;
                        o_ovf <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Leading-zero mask from the held result; the ones digit is never blanked.
    always_comb begin
        logic run;
        o_blank = '0;
        run     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run        = run & (o_bcd[4*k +: 4] == 4'd0);
            o_blank[k] = run;
        end
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, with a start/valid handshake. It replaces the single-cycle divider-based conversion in the 7-segment display path and feeds the digit mux/segment decoder. It adds saturation and overflow reporting for out-of-range inputs and a leading-zero blanking mask. No dividers or multipliers are used.

## Interface
Parameters:
- BIN_W, default 14, binary input width; must be ≥ 1.
- DIGITS, default 4, number of BCD output digits; must be ≥ 1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  conversion request, sampled only in IDLE.
- i_bin  in  BIN_W  unsigned binary value, captured on an accepted i_start.
- o_busy  out  1  high while a conversion is in progress (SHIFT and DONE states).
- o_valid  out  1  one-cycle pulse marking that o_bcd, o_ovf and o_blank have been updated.
- o_bcd  out  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], digit 0 is the ones digit.
- o_ovf  out  1  set when the last input was ≥ 10^DIGITS.
- o_blank  out  DIGITS  leading-zero mask; bit k=1 when digit k and all higher digits are 0, for k ≥ 1; bit 0 is always 0.

## Operation
- State machine IDLE → SHIFT → DONE → IDLE.
- IDLE: if i_start=1, capture i_bin into the shift register, clear the BCD scratch and overflow flag, load bit counter = BIN_W, go to SHIFT. i_start is ignored in SHIFT and DONE and does not queue.
- SHIFT, one iteration per cycle:
  - Every scratch digit ≥ 5 gets +3.
  - Then {scratch, shift reg} shifts left by 1, taking the binary MSB into scratch bit 0.
  - The bit shifted out of the top digit's MSB ORs into the overflow flag.
  - The counter decrements; the last iteration goes to DONE.
- DONE: register outputs and assert o_valid for this cycle only, then return to IDLE.
  - No overflow: o_bcd = scratch, o_ovf = 0.
  - Overflow: o_bcd = all digits 9 (saturation), o_ovf = 1.
  - o_blank is derived from the registered o_bcd value.
- o_bcd, o_ovf and o_blank hold their values between o_valid pulses.
- Arithmetic: the add-3 operates on 4-bit digits with no carry between digits. The overflow flag is sticky for the whole conversion.

## Timing
- Reset values: o_busy=0, o_valid=0, o_bcd=0, o_ovf=0, o_blank = all ones except bit 0. State returns to IDLE.
- Accept at edge N (IDLE with i_start=1) → SHIFT occupies edges N+1 through N+BIN_W → o_valid high after edge N+BIN_W+1. Latency is BIN_W+1 cycles.
- o_busy rises the cycle after acceptance and falls with the return to IDLE (same edge o_valid falls).
- Minimum spacing between accepted starts is BIN_W+2 cycles.
- i_rst during SHIFT or DONE aborts the conversion. Outputs take reset values on that edge, and no o_valid is issued.
- i_rst and i_start both high: reset wins, the request is dropped.
- BIN_W small enough that overflow is impossible (2^BIN_W ≤ 10^DIGITS): o_ovf stays 0.

## Test plan
- Defaults, i_bin=1234, single start → o_valid exactly 15 cycles later, o_bcd=0x1234, o_ovf=0, o_blank=4'b0000.
- i_bin=0 → o_bcd=0x0000, o_blank=4'b1110. Then i_bin=7 → o_bcd=0x0007, o_blank=4'b1110. Then i_bin=9999 → o_bcd=0x9999, o_ovf=0.
- i_bin=16383 and i_bin=10000 → o_bcd=0x9999, o_ovf=1. Next conversion of 42 → o_bcd=0x0042, o_ovf=0, o_blank=4'b1100.
- Convert 500 with i_start also pulsed (i_bin=77) mid-SHIFT → exactly one o_valid, result 0x0500, o_busy continuous.
- i_rst asserted 5 cycles into a conversion → next cycle all outputs at reset values, no o_valid. A fresh start with 321 → 0x0321.
- BIN_W=8, DIGITS=3: i_bin=255 → o_bcd=12'h255, o_valid 9 cycles after start, o_ovf=0.
